write_queue: RTL and testbench

WRITE_QUEUE -- requirements
Module: write_queue

---
 rtl/write_queue.sv | 102 ++++++++++
 tb/tb_write_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_queue.sv
// Write queue: a FIFO that feeds a downstream memory-write stage through a
// four-state issue FSM, which spaces write requests at least four cycles apart.
module write_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             wr_ready,
  output logic             wr_start,
  output logic [WIDTH-1:0] wr_data,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  // state  | meaning
  // IDLE   | waiting for a queued word and an idle write stage
  // ISSUE  | wr_start high for one cycle, head word popped
  // GUARD  | wr_ready ignored while the write stage picks up the request
  // WAIT   | waiting for the write stage to report idle again
  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W + 1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_en;
  logic             r_nonempty;
  logic             r_wr_start;
  logic [WIDTH-1:0] r_wr_data;
  logic             w_push;
  logic             w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == LP_DEPTH);
  assign in_ready = r_en & ~full;
  assign count    = r_count;
  assign wr_start = r_wr_start;
  assign wr_data  = r_wr_data;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = r_wr_start;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_en       <= 1'b0;
      r_nonempty <= 1'b0;
    end else begin
      r_en       <= 1'b1;
      r_nonempty <= (r_count != '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The occupancy seen by IDLE is one cycle old, which sets the push-to-issue
  // latency at two edges; a pop is never within two cycles of IDLE, so the
  // delayed flag cannot claim a word that has already left.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (r_nonempty && !empty && wr_ready) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = GUARD;
      GUARD:   w_state_nxt = WAIT;
      WAIT:    if (wr_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wr_start <= 1'b0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_start <= (w_state_nxt == ISSUE);
      if (w_state_nxt == ISSUE) r_wr_data <= r_mem[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_write_queue.sv
// Bench for write_queue: directed scenarios plus random traffic, with a
// queue-based reference model and a monitor that checks every write request.
module tb_write_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             wr_ready = 1'b0;
  logic             in_ready;
  logic             wr_start;
  logic [WIDTH-1:0] wr_data;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;

  write_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_ready(wr_ready), .wr_start(wr_start),
    .wr_data(wr_data), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words in arrival order and the occupancy they imply.
  logic [WIDTH-1:0] exp_q[$];
  int               m_cnt = 0;
  int               m_acc = 0;
  bit               m_en = 1'b0;
  bit               s_start = 1'b0;
  logic [WIDTH-1:0] m_last = '0;
  int               gap = 100;
  int               n_pulses = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_cnt = 0;
      m_en  = 1'b0;
      exp_q.delete();
    end else begin
      if (in_valid && m_en && m_cnt < DEPTH) begin
        exp_q.push_back(in_data);
        m_cnt++;
        m_acc++;
      end
      if (s_start) m_cnt--;
      m_en = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_count", 64'(count), 64'(0));
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_full", 64'(full), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_wr_start", 64'(wr_start), 64'(0));
      check("rst_wr_data", 64'(wr_data), 64'(0));
      m_last  = '0;
      gap     = 100;
      s_start = 1'b0;
    end else begin
      check("count", 64'(count), 64'(m_cnt));
      check("empty", 64'(empty), 64'(m_cnt == 0));
      check("full", 64'(full), 64'(m_cnt == DEPTH));
      check("in_ready", 64'(in_ready), 64'(m_en && m_cnt < DEPTH));
      gap++;
      if (wr_start) begin
        n_pulses++;
        check("wr_start_has_word", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          m_last = exp_q.pop_front();
          check("wr_data", 64'(wr_data), 64'(m_last));
        end
        check("wr_start_spacing", 64'(gap >= 4), 64'(1));
        gap = 0;
      end else begin
        check("wr_data_hold", 64'(wr_data), 64'(m_last));
      end
      s_start = wr_start;
    end
  end

  task automatic wait_start(input int limit, output bit found);
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (wr_start) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    int  p0;
    int  prev;
    int  npul;
    int  bad;
    int  target;
    bit  found;

    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // single word and push-to-issue latency
    @(negedge clk);
    #1 in_valid = 1'b1; in_data = 32'hDEADBEEF;
    p0 = n_pulses;
    @(negedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (wr_start) begin
        lat = k;
        break;
      end
    end
    check("single_latency", 64'(lat), 64'(2));
    check("single_data", 64'(wr_data), 64'(32'hDEADBEEF));
    repeat (4) @(negedge clk);
    check("single_pulses", 64'(n_pulses - p0), 64'(1));
    check("single_count", 64'(count), 64'(0));

    // fill with the write stage busy
    #1 wr_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      @(negedge clk);
      if (i == 9) check("fill_in_ready_9th", 64'(in_ready), 64'(0));
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("fill_count", 64'(count), 64'(8));
    check("fill_full", 64'(full), 64'(1));

    // drain from full at a steady wr_ready
    #1 wr_ready = 1'b1;
    prev = -1; npul = 0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (wr_start) begin
        if (prev >= 0 && c - prev != 4) bad++;
        prev = c;
        npul++;
      end
    end
    check("drain_pulses", 64'(npul), 64'(8));
    check("drain_spacing", 64'(bad), 64'(0));
    check("drain_empty", 64'(empty), 64'(1));

    // push and pop on the same edge with three words queued
    #1 wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(32'h100 + i);
      @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    wr_ready = 1'b1;
    p0 = n_pulses;
    wait_start(20, found);
    check("sim_issue_seen", 64'(found), 64'(1));
    check("sim_count_before", 64'(count), 64'(3));
    #1 in_valid = 1'b1; in_data = 32'h200;
    @(negedge clk);
    check("sim_count_after", 64'(count), 64'(3));
    #1 in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("sim_pulses", 64'(n_pulses - p0), 64'(4));
    check("sim_drained", 64'(count), 64'(0));

    // reset while a request is on the wire
    #1 in_valid = 1'b1; in_data = 32'h12345678;
    @(negedge clk);
    #1 in_valid = 1'b0;
    wait_start(20, found);
    check("rst_issue_seen", 64'(found), 64'(1));
    #1 reset = 1'b0;
    #1;
    check("rst_mid_wr_start", 64'(wr_start), 64'(0));
    check("rst_mid_count", 64'(count), 64'(0));
    check("rst_mid_empty", 64'(empty), 64'(1));
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 in_valid = 1'b1; in_data = 32'hCAFEF00D;
    @(negedge clk);
    #1 in_valid = 1'b0;
    wait_start(20, found);
    check("post_rst_issue", 64'(found), 64'(1));
    check("post_rst_data", 64'(wr_data), 64'(32'hCAFEF00D));

    // random traffic across several pointer wraps
    target = m_acc + 40;
    for (int c = 0; c < 3000 && m_acc < target; c++) begin
      @(negedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      wr_ready = ($urandom_range(0, 3) != 0);
    end
    check("rand_accepted", 64'(m_acc >= target), 64'(1));
    #1 in_valid = 1'b0; wr_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && m_cnt == 0) break;
    end
    check("rand_queue_drained", 64'(exp_q.size()), 64'(0));
    check("rand_count_zero", 64'(count), 64'(0));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
